// File: rtl/reg_bus_pkg.sv
// Shared types and limits for the register-bus master.
package reg_bus_pkg;

    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned RD_CNT_W   = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } bus_state_e;

endpackage

// File: rtl/reg_bus_rd_mux.sv
// Selects one slave's slice out of the concatenated slave read buses.
module reg_bus_rd_mux #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic [NUM_REGS*REG_WIDTH-1:0] rd_bus,
    input  logic [ADDR_WIDTH-1:0]         sel_addr,
    output logic [REG_WIDTH-1:0]          rd_data
);

    // Compare at full width so a narrow slave count never aliases onto a wider address.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(sel_addr) == i) begin
                rd_data = rd_bus[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

endmodule

// File: rtl/reg_bus_master.sv
// Single-outstanding request/response master driving a bank of register slaves
// over a shared select/data bus with a fixed read latency.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [REG_WIDTH-1:0]          req_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [REG_WIDTH-1:0]          rsp_data,
    output logic                          rsp_err,
    output logic [NUM_REGS-1:0]           reg_wr_sel,
    output logic                          reg_wr_rd,
    output logic [REG_WIDTH-1:0]          reg_wr_data,
    input  logic [NUM_REGS*REG_WIDTH-1:0] reg_rd_out
);

    localparam logic [RD_CNT_W-1:0] LAST_CNT = (RD_LAT > 0) ? RD_CNT_W'(RD_LAT - 1) : '0;

    bus_state_e              state_q, state_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [RD_CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [NUM_REGS-1:0]     sel_q, sel_d;
    logic                    bus_wr_q, bus_wr_d;
    logic [REG_WIDTH-1:0]    bus_data_q, bus_data_d;
    logic [REG_WIDTH-1:0]    rd_sample;
    logic                    addr_oor;

    reg_bus_rd_mux #(
        .REG_WIDTH  (REG_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_mux (
        .rd_bus   (reg_rd_out),
        .sel_addr (addr_q),
        .rd_data  (rd_sample)
    );

    assign addr_oor = (32'(req_addr) >= NUM_REGS);

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        // Bus outputs are only non-zero for the single ACCESS cycle.
        sel_d      = '0;
        bus_wr_d   = 1'b0;
        bus_data_d = '0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wr_d       = req_wr;
                    addr_d     = req_addr;
                    cnt_d      = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    if (addr_oor) begin
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        sel_d      = {{(NUM_REGS-1){1'b0}}, 1'b1} << req_addr;
                        bus_wr_d   = req_wr;
                        bus_data_d = req_data;
                        state_d    = StAccess;
                    end
                end
            end

            StAccess: begin
                if (wr_q) begin
                    state_d = StResp;
                end else if (RD_LAT == 0) begin
                    rsp_data_d = rd_sample;
                    state_d    = StResp;
                end else begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (cnt_q == LAST_CNT) begin
                    rsp_data_d = rd_sample;
                    cnt_d      = '0;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q + RD_CNT_W'(1);
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            sel_q      <= '0;
            bus_wr_q   <= 1'b0;
            bus_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            sel_q      <= sel_d;
            bus_wr_q   <= bus_wr_d;
            bus_data_q <= bus_data_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign reg_wr_sel  = sel_q;
    assign reg_wr_rd   = bus_wr_q;
    assign reg_wr_data = bus_data_q;

    a_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(reg_wr_sel));

    a_rsp_held: assert property (@(posedge clk) disable iff (rst)
        rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_data) && $stable(rsp_err));

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench: an 8-slave RD_LAT=1 master with registered slaves and a
// 6-slave RD_LAT=0 master with combinational slaves.
module tb_reg_bus_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Master A: NUM_REGS=8, RD_LAT=1
    logic        a_req_valid, a_req_ready, a_req_wr;
    logic [2:0]  a_req_addr;
    logic [31:0] a_req_data;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_data;
    logic [7:0]  a_sel;
    logic        a_rd_wr;
    logic [31:0] a_wdata;
    logic [255:0] a_rd_out;
    logic [31:0] a_mem [8];
    int          a_pulses [8] = '{default: 0};

    // Master B: NUM_REGS=6, RD_LAT=0
    logic        b_req_valid, b_req_ready, b_req_wr;
    logic [2:0]  b_req_addr;
    logic [31:0] b_req_data;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_data;
    logic [5:0]  b_sel;
    logic        b_rd_wr;
    logic [31:0] b_wdata;
    logic [191:0] b_rd_out;
    int          b_sel_cycles = 0;

    reg_bus_master #(
        .REG_WIDTH (32), .NUM_REGS (8), .ADDR_WIDTH (3), .RD_LAT (1)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (a_req_valid),
        .req_ready   (a_req_ready),
        .req_wr      (a_req_wr),
        .req_addr    (a_req_addr),
        .req_data    (a_req_data),
        .rsp_valid   (a_rsp_valid),
        .rsp_ready   (a_rsp_ready),
        .rsp_data    (a_rsp_data),
        .rsp_err     (a_rsp_err),
        .reg_wr_sel  (a_sel),
        .reg_wr_rd   (a_rd_wr),
        .reg_wr_data (a_wdata),
        .reg_rd_out  (a_rd_out)
    );

    reg_bus_master #(
        .REG_WIDTH (32), .NUM_REGS (6), .ADDR_WIDTH (3), .RD_LAT (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (b_req_valid),
        .req_ready   (b_req_ready),
        .req_wr      (b_req_wr),
        .req_addr    (b_req_addr),
        .req_data    (b_req_data),
        .rsp_valid   (b_rsp_valid),
        .rsp_ready   (b_rsp_ready),
        .rsp_data    (b_rsp_data),
        .rsp_err     (b_rsp_err),
        .reg_wr_sel  (b_sel),
        .reg_wr_rd   (b_rd_wr),
        .reg_wr_data (b_wdata),
        .reg_rd_out  (b_rd_out)
    );

    // Registered slaves: data valid only the cycle after their select, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            a_rd_out[i*32 +: 32] <= a_sel[i] ? a_mem[i] : (32'hDEAD_0000 | 32'(i));
            if (a_sel[i] && a_rd_wr) a_mem[i] <= a_wdata;
            if (a_sel[i]) a_pulses[i] <= a_pulses[i] + 1;
        end
        if (|b_sel) b_sel_cycles <= b_sel_cycles + 1;
    end

    always_comb begin
        b_rd_out = '0;
        for (int i = 0; i < 6; i++) begin
            b_rd_out[i*32 +: 32] = b_sel[i] ? {16'hB0B0, 16'(i)} : 32'hDEAD_BEEF;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        a_req_valid = 1'b1;
        a_req_wr    = 1'b0;
        a_req_addr  = addr;
        a_req_data  = '0;
        check_eq({tag, "_ready"}, 64'(a_req_ready), 64'd1);
        tick();
        a_req_valid = 1'b0;
        check_eq({tag, "_sel"}, 64'(a_sel), 64'(8'b1 << addr));
        tick();
        check_eq({tag, "_wait"}, 64'({a_sel, a_rsp_valid}), 64'd0);
        tick();
        check_eq({tag, "_rsp"}, 64'({a_rsp_valid, a_rsp_err, a_rsp_data}), 64'({2'b10, exp}));
        tick();
        check_eq({tag, "_idle"}, 64'({a_rsp_valid, a_req_ready}), 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0, p7;
        for (int i = 0; i < 8; i++) a_mem[i] = {16'hC0DE, 16'(i)};
        a_mem[5] = 32'h0000_0001;
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_data = '0;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_data = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        tick();
        tick();
        check_eq("a_reset_ctl", 64'({a_req_ready, a_rsp_valid, a_rsp_err, a_rd_wr}), 64'b1000);
        check_eq("a_reset_bus", 64'({a_sel, a_wdata}), 64'd0);
        check_eq("a_reset_rsp", 64'(a_rsp_data), 64'd0);
        check_eq("b_reset_ctl", 64'({b_req_ready, b_rsp_valid, b_rsp_err, b_rd_wr, b_sel}), 64'h200);
        rst = 1'b0;
        tick();

        // Write addr 2
        a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 3'd2; a_req_data = 32'hA5A5_0001;
        check_eq("wr_hs_ready", 64'(a_req_ready), 64'd1);
        tick();
        a_req_valid = 1'b0;
        check_eq("wr_sel", 64'(a_sel), 64'(8'b0000_0100));
        check_eq("wr_bus", 64'({a_rd_wr, a_wdata}), 64'({1'b1, 32'hA5A5_0001}));
        check_eq("wr_busy", 64'({a_req_ready, a_rsp_valid}), 64'b00);
        tick();
        check_eq("wr_bus_off", 64'({a_sel, a_rd_wr, a_wdata}), 64'd0);
        check_eq("wr_rsp", 64'({a_rsp_valid, a_rsp_err, a_rsp_data}), 64'({2'b10, 32'h0}));
        tick();
        check_eq("wr_done", 64'({a_rsp_valid, a_req_ready}), 64'b01);

        // Reads with RD_LAT=1: response on the third cycle after the handshake
        a_read(3'd5, 32'h0000_0001, "rd5");
        a_read(3'd2, 32'hA5A5_0001, "rd2");

        // Backpressure with a second request waiting
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 3'd7; a_req_data = '0;
        tick();
        a_req_wr = 1'b1; a_req_addr = 3'd3; a_req_data = 32'h0BAD_F00D;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            check_eq("bp_hold", 64'({a_rsp_valid, a_req_ready, a_rsp_err, a_sel, a_rsp_data}),
                     64'({3'b100, 8'h00, 32'hC0DE_0007}));
            tick();
        end
        a_rsp_ready = 1'b1;
        check_eq("bp_release_busy", 64'({a_req_ready, a_rsp_valid}), 64'b01);
        tick();
        check_eq("bp_accept", 64'({a_req_ready, a_rsp_valid}), 64'b10);
        tick();
        a_req_valid = 1'b0;
        check_eq("bp_second_bus", 64'({a_sel, a_rd_wr, a_wdata}), 64'({8'h08, 1'b1, 32'h0BAD_F00D}));
        tick();
        check_eq("bp_second_rsp", 64'({a_rsp_valid, a_rsp_err, a_rsp_data}), 64'({2'b10, 32'h0}));
        tick();
        a_read(3'd3, 32'h0BAD_F00D, "rd3");

        // Reset while the select is asserted
        a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 3'd6;
        tick();
        a_req_valid = 1'b0;
        check_eq("rst_pre_sel", 64'(a_sel), 64'(8'h40));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_abort", 64'({a_sel, a_rsp_valid, a_req_ready}), 64'({8'h00, 2'b01}));
        tick();
        tick();
        check_eq("rst_no_rsp", 64'({a_rsp_valid, a_req_ready}), 64'b01);
        a_read(3'd6, 32'hC0DE_0006, "rst_after");

        // Back-to-back reads 0 then 7; address change during ACCESS is ignored
        p0 = a_pulses[0];
        p7 = a_pulses[7];
        a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 3'd0;
        tick();
        a_req_addr = 3'd7;
        check_eq("b2b_sel0", 64'(a_sel), 64'(8'h01));
        tick();
        tick();
        check_eq("b2b_rsp0", 64'({a_rsp_valid, a_rsp_err, a_rsp_data}), 64'({2'b10, 32'hC0DE_0000}));
        tick();
        check_eq("b2b_hs1", 64'({a_req_ready, a_rsp_valid}), 64'b10);
        tick();
        a_req_valid = 1'b0;
        check_eq("b2b_sel7", 64'(a_sel), 64'(8'h80));
        tick();
        tick();
        check_eq("b2b_rsp1", 64'({a_rsp_valid, a_rsp_err, a_rsp_data}), 64'({2'b10, 32'hC0DE_0007}));
        tick();
        check_eq("b2b_pulses", {32'(a_pulses[0] - p0), 32'(a_pulses[7] - p7)}, {32'd1, 32'd1});

        // Master B: out-of-range addresses 7 and 6
        b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 3'd7; b_req_data = '0;
        check_eq("oor7_ready", 64'(b_req_ready), 64'd1);
        tick();
        b_req_valid = 1'b0;
        check_eq("oor7_rsp", 64'({b_rsp_valid, b_rsp_err, b_sel, b_rsp_data}),
                 64'({2'b11, 6'b0, 32'h0}));
        tick();
        check_eq("oor7_idle", 64'({b_rsp_valid, b_req_ready}), 64'b01);
        b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 3'd6; b_req_data = 32'hFFFF_FFFF;
        tick();
        b_req_valid = 1'b0;
        check_eq("oor6_rsp", 64'({b_rsp_valid, b_rsp_err, b_sel, b_rsp_data}),
                 64'({2'b11, 6'b0, 32'h0}));
        tick();
        check_eq("oor_no_sel", 64'(b_sel_cycles), 64'd0);

        // Master B: RD_LAT=0 read of slave 5 and write of slave 0
        b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 3'd5; b_req_data = '0;
        tick();
        b_req_valid = 1'b0;
        check_eq("b_rd5_sel", 64'({b_sel, b_rd_wr}), 64'({6'b10_0000, 1'b0}));
        tick();
        check_eq("b_rd5_rsp", 64'({b_rsp_valid, b_rsp_err, b_sel, b_rsp_data}),
                 64'({2'b10, 6'b0, 32'hB0B0_0005}));
        tick();
        b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 3'd0; b_req_data = 32'h1234_5678;
        tick();
        b_req_valid = 1'b0;
        check_eq("b_wr0_bus", 64'({b_sel, b_rd_wr, b_wdata}), 64'({6'b00_0001, 1'b1, 32'h1234_5678}));
        tick();
        check_eq("b_wr0_rsp", 64'({b_rsp_valid, b_rsp_err, b_rsp_data}), 64'({2'b10, 32'h0}));
        tick();
        check_eq("b_wr0_idle", 64'({b_rsp_valid, b_req_ready}), 64'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
